// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit:
// exception codes, FSM encodings and the default trap vector.
package pipe_ctrl_pkg;

    localparam logic [4:0]  EXC_ERET     = 5'h1F;
    localparam logic [31:0] EXC_BASE_DEF = 32'h0000_0020;

    // FREEZE stays a legal encoding for future multi-cycle freezes.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FREEZE = 2'd1,
        FLUSH  = 2'd2
    } pc_state_e;

    function automatic logic [31:0] redirect_pc(
        input logic [4:0]  code,
        input logic [31:0] epc,
        input logic [31:0] base
    );
        return (code == EXC_ERET) ? epc : base;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stall/flush/redirect bundle between the pipeline and pipe_ctrl.
// master = controller side, slave = pipeline side.
interface pipe_ctrl_if #(
    parameter int STAGES = 6
);
    logic [STAGES-1:0] stallreq_i;
    logic              exc_req_i;
    logic [4:0]        exc_code_i;
    logic [31:0]       epc_i;
    logic [STAGES-1:0] stall_o;
    logic              flush_o;
    logic [31:0]       new_pc_o;

    modport master (
        input  stallreq_i, exc_req_i, exc_code_i, epc_i,
        output stall_o, flush_o, new_pc_o
    );

    modport slave (
        output stallreq_i, exc_req_i, exc_code_i, epc_i,
        input  stall_o, flush_o, new_pc_o
    );
endinterface

// File: rtl/pipe_ctrl_stall_mask_gen.sv
// Thermometer stall mask: the highest requesting stage and
// every earlier stage are held.
module stall_mask_gen #(
    parameter int STAGES = 6
) (
    input  logic [STAGES-1:0] req_i,
    output logic [STAGES-1:0] mask_o
);

    logic acc;

    // Scan from writeback down; once a request is seen, all
    // lower stages stall too.
    always_comb begin
        acc    = 1'b0;
        mask_o = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc       = acc | req_i[k];
            mask_o[k] = acc;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/redirect controller.
// Optional stall-cycle counter under PIPE_CTRL_STALL_CNT_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          STAGES       = 6,
    parameter int          FLUSH_CYCLES = 1,
    parameter logic [31:0] EXC_BASE     = EXC_BASE_DEF
) (
    input  logic        clk,
    input  logic        rst,
`ifdef PIPE_CTRL_STALL_CNT_EN
    output logic [31:0] stall_cnt_o,
`endif
    pipe_ctrl_if.master bus
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);

    pc_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [31:0]       new_pc_q, new_pc_d;
    logic [STAGES-1:0] mask;
    logic [STAGES-1:0] stall;
    logic              flush;

    stall_mask_gen #(
        .STAGES (STAGES)
    ) u_mask (
        .req_i  (bus.stallreq_i),
        .mask_o (mask)
    );

    // Outputs are forced quiet while rst is held so a mid-flush
    // reset drops the redirect immediately.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        new_pc_d = new_pc_q;
        stall    = '0;
        flush    = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (bus.exc_req_i) begin
                        stall    = '1;
                        new_pc_d = redirect_pc(bus.exc_code_i,
                                               bus.epc_i, EXC_BASE);
                        cnt_d    = CNT_LOAD;
                        state_d  = FLUSH;
                    end else begin
                        stall = mask;
                    end
                end
                FLUSH: begin
                    flush = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            new_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            new_pc_q <= new_pc_d;
        end
    end

    assign bus.stall_o  = stall;
    assign bus.flush_o  = flush;
    assign bus.new_pc_o = new_pc_q;

`ifdef PIPE_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        cnt_en;

    // Only ordinary RUN stalls count; exception cycles do not.
    assign cnt_en = (state_q == RUN) && !bus.exc_req_i && (|mask);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cnt_en && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomised self-checking bench for pipe_ctrl with FLUSH_CYCLES 1 and 3.
// Counter checks are active when PIPE_CTRL_STALL_CNT_EN is defined.
module tb_pipe_ctrl;

    localparam int S = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [S-1:0] req  = '0;
    logic        exc  = 1'b0;
    logic [4:0]  code = '0;
    logic [31:0] epc  = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.STAGES(S)) bus0 ();
    pipe_ctrl_if #(.STAGES(S)) bus1 ();

    assign bus0.stallreq_i = req;
    assign bus0.exc_req_i  = exc;
    assign bus0.exc_code_i = code;
    assign bus0.epc_i      = epc;
    assign bus1.stallreq_i = req;
    assign bus1.exc_req_i  = exc;
    assign bus1.exc_code_i = code;
    assign bus1.epc_i      = epc;

`ifdef PIPE_CTRL_STALL_CNT_EN
    logic [31:0] cnt0, cnt1;
`endif

    pipe_ctrl #(.STAGES(S), .FLUSH_CYCLES(1)) u0 (
        .clk (clk),
        .rst (rst),
`ifdef PIPE_CTRL_STALL_CNT_EN
        .stall_cnt_o (cnt0),
`endif
        .bus (bus0)
    );

    pipe_ctrl #(.STAGES(S), .FLUSH_CYCLES(3)) u1 (
        .clk (clk),
        .rst (rst),
`ifdef PIPE_CTRL_STALL_CNT_EN
        .stall_cnt_o (cnt1),
`endif
        .bus (bus1)
    );

    // Behavioural model: remaining flush cycles, held PC, stall count.
    int          fl  [2];
    logic [31:0] pcm [2];
    logic [31:0] cm  [2];

    function automatic int fcyc(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [S-1:0] therm(logic [S-1:0] r);
        int hi;
        hi = -1;
        for (int k = 0; k < S; k++) if (r[k]) hi = k;
        return S'((1 << (hi + 1)) - 1);
    endfunction

    task automatic cmp(string nm, int inst, logic [31:0] act,
                       logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[u%0d] t=%0t got %h want %h",
                     nm, inst, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                fl[i] = 0; pcm[i] = '0; cm[i] = '0;
            end else if (fl[i] > 0) begin
                fl[i] = fl[i] - 1;
            end else if (exc) begin
                fl[i]  = fcyc(i);
                pcm[i] = (code == 5'h1F) ? epc : 32'h20;
            end else if (req != '0 && cm[i] != 32'hFFFF_FFFF) begin
                cm[i] = cm[i] + 1;
            end
        end
    end

    // Compare every cycle, well clear of both clock edges.
    always @(negedge clk) begin
        #3;
        for (int i = 0; i < 2; i++) begin
            logic [S-1:0] es;
            logic         ef;
            logic [31:0]  ep;
            logic [S-1:0] ds;
            logic         df;
            logic [31:0]  dp;
            ds = (i == 0) ? bus0.stall_o  : bus1.stall_o;
            df = (i == 0) ? bus0.flush_o  : bus1.flush_o;
            dp = (i == 0) ? bus0.new_pc_o : bus1.new_pc_o;
            if (rst) begin
                es = '0; ef = 1'b0; ep = '0;
            end else if (fl[i] > 0) begin
                es = '0; ef = 1'b1; ep = pcm[i];
            end else if (exc) begin
                es = '1; ef = 1'b0; ep = pcm[i];
            end else begin
                es = therm(req); ef = 1'b0; ep = pcm[i];
            end
            cmp("stall", i, 32'(ds), 32'(es));
            cmp("flush", i, 32'(df), 32'(ef));
            cmp("new_pc", i, dp, rst ? 32'h0 : ep);
`ifdef PIPE_CTRL_STALL_CNT_EN
            cmp("stall_cnt", i, (i == 0) ? cnt0 : cnt1,
                rst ? 32'h0 : cm[i]);
`endif
        end
    end

    task automatic step(logic r, logic [S-1:0] q, logic e,
                        logic [4:0] c, logic [31:0] p);
        @(negedge clk);
        #1;
        rst = r; req = q; exc = e; code = c; epc = p;
        #3;
    endtask

    initial begin
        // Reset with random inputs.
        for (int i = 0; i < 3; i++)
            step(1'b1, S'($urandom), 1'($urandom), 5'($urandom), $urandom);
        cmp("rst_stall", 0, 32'(bus0.stall_o), 32'h0);
        cmp("rst_flush", 1, 32'(bus1.flush_o), 32'h0);
        cmp("rst_pc", 0, bus0.new_pc_o, 32'h0);
`ifdef PIPE_CTRL_STALL_CNT_EN
        cmp("rst_cnt", 0, cnt0, 32'h0);
`endif
        // Priority mask.
        step(1'b0, 6'b000100, 1'b0, 5'h0, 32'h0);
        cmp("prio_a", 0, 32'(bus0.stall_o), 32'h07);
        step(1'b0, 6'b001100, 1'b0, 5'h0, 32'h0);
        cmp("prio_b", 0, 32'(bus0.stall_o), 32'h0F);
        step(1'b0, 6'b000000, 1'b0, 5'h0, 32'h0);
        cmp("prio_c", 1, 32'(bus1.stall_o), 32'h00);
        // Exception to EXC_BASE.
        step(1'b0, 6'b001000, 1'b1, 5'h08, 32'hDEAD_BEEF);
        cmp("exc_n_stall", 0, 32'(bus0.stall_o), 32'h3F);
        step(1'b0, 6'b001000, 1'b0, 5'h08, 32'h0);
        cmp("exc_n1_flush", 0, 32'(bus0.flush_o), 32'h1);
        cmp("exc_n1_pc", 0, bus0.new_pc_o, 32'h20);
        cmp("exc_n1_stall", 0, 32'(bus0.stall_o), 32'h0);
        step(1'b0, 6'b001000, 1'b0, 5'h08, 32'h0);
        cmp("exc_n2_flush", 0, 32'(bus0.flush_o), 32'h0);
        cmp("exc_n2_stall", 0, 32'(bus0.stall_o), 32'h0F);
        cmp("exc_n2_u1", 1, 32'(bus1.flush_o), 32'h1);
        step(1'b0, 6'b000000, 1'b0, 5'h0, 32'h0);
        step(1'b0, 6'b000000, 1'b0, 5'h0, 32'h0);
        // ERET with a second request inside the flush window.
        step(1'b0, 6'b000001, 1'b1, 5'h1F, 32'h1000_0040);
        step(1'b0, 6'b000000, 1'b0, 5'h0, 32'h0);
        cmp("eret_n1", 1, bus1.new_pc_o, 32'h1000_0040);
        step(1'b0, 6'b000000, 1'b1, 5'h08, 32'h0);
        cmp("eret_n2_flush", 1, 32'(bus1.flush_o), 32'h1);
        step(1'b0, 6'b000000, 1'b0, 5'h0, 32'h0);
        cmp("eret_n3_pc", 1, bus1.new_pc_o, 32'h1000_0040);
        cmp("eret_n3_flush", 1, 32'(bus1.flush_o), 32'h1);
        step(1'b0, 6'b000010, 1'b0, 5'h0, 32'h0);
        cmp("eret_n4_flush", 1, 32'(bus1.flush_o), 32'h0);
        cmp("eret_n4_stall", 1, 32'(bus1.stall_o), 32'h03);
        // Reset in the middle of a flush.
        step(1'b0, 6'b000000, 1'b1, 5'h1F, 32'h0000_1234);
        step(1'b1, 6'b010000, 1'b0, 5'h0, 32'h0);
        cmp("rst_mid_flush", 1, 32'(bus1.flush_o), 32'h0);
        cmp("rst_mid_stall", 1, 32'(bus1.stall_o), 32'h0);
        step(1'b1, 6'b010000, 1'b0, 5'h0, 32'h0);
        step(1'b0, 6'b000000, 1'b0, 5'h0, 32'h0);
        cmp("rst_mid_run", 1, 32'(bus1.flush_o), 32'h0);
`ifdef PIPE_CTRL_STALL_CNT_EN
        for (int i = 0; i < 10; i++)
            step(1'b0, S'(i + 1), 1'b0, 5'h0, 32'h0);
        step(1'b0, 6'b111111, 1'b1, 5'h0, 32'h0);
        for (int i = 0; i < 4; i++)
            step(1'b0, 6'b000000, 1'b0, 5'h0, 32'h0);
        cmp("cnt_ten", 0, cnt0, 32'd10);
        @(negedge clk);
        #1;
        force u0.stall_cnt_q = 32'hFFFF_FFFD;
        cm[0] = 32'hFFFF_FFFD;
        #1;
        release u0.stall_cnt_q;
        for (int i = 0; i < 5; i++)
            step(1'b0, 6'b000001, 1'b0, 5'h0, 32'h0);
        cmp("cnt_sat", 0, cnt0, 32'hFFFF_FFFF);
`endif
        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            logic r;
            r = ($urandom_range(0, 59) == 0);
            step(r, ($urandom_range(0, 2) == 0) ? '0 : S'($urandom),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 2) == 0) ? 5'h1F : 5'($urandom),
                 $urandom);
            if (r) step(1'b1, S'($urandom), 1'($urandom), 5'h0, $urandom);
        end
        step(1'b0, '0, 1'b0, 5'h0, 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit for the in-order core. Merges per-stage stall requests into a per-stage stall vector, so the highest requesting stage freezes itself and every earlier stage. Sequences exception and ERET redirects through a freeze cycle and a multi-cycle flush window, and drives the redirect PC to the fetch stage. Sits beside the pipeline registers and drives all of their stall and flush inputs.

## Interface
- STAGES, 6: number of pipeline stages; bit 0 is PC, bit STAGES-1 is writeback.
- FLUSH_CYCLES, 1: cycles flush stays high per redirect (≥1).
- EXC_BASE, 32'h0000_0020: redirect target for all non-ERET exception codes.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- stallreq_i  in  STAGES  bit k = stage k requests a stall.
- exc_req_i  in  1  exception or ERET present at commit this cycle.
- exc_code_i  in  5  exception code; EXC_ERET = return.
- epc_i  in  32  EPC value; used only for ERET.
- stall_o  out  STAGES  bit k = hold stage k.
- flush_o  out  1  clear all pipeline registers.
- new_pc_o  out  32  redirect target; valid while flush_o=1.
- stall_cnt_o  out  32  stall-cycle counter; exists only under the macro.

## Operation
- FSM states: RUN, FREEZE, FLUSH. Reset state is RUN.
- RUN, exc_req_i=0:
  - k = highest set index of stallreq_i.
  - stall_o[k:0]=1 and the upper bits are 0.
  - If no bit is set, stall_o=0.
  - Combinational from stallreq_i.
  - flush_o=0.
- RUN, exc_req_i=1:
  - Exception overrides any stallreq_i; stall_o = all ones this cycle.
  - Register new_pc_o = epc_i if exc_code_i==EXC_ERET, else EXC_BASE.
  - Next state FREEZE if FLUSH_CYCLES>1 is not required; go directly to FLUSH and load the flush counter with FLUSH_CYCLES-1.
  - FREEZE is the exc_req_i cycle itself; there is no extra state cycle.
- FLUSH:
  - flush_o=1 and stall_o=0.
  - stallreq_i and exc_req_i are ignored.
  - Counter decrements each cycle. When it reaches 0, return to RUN on the next edge.
- new_pc_o holds its last value outside FLUSH.
- Reset values: stall_o=0, flush_o=0, new_pc_o=0, counter=0, stall_cnt_o=0.
- Reset asserted mid-FLUSH: immediate return to RUN with all outputs at their reset values. The redirect is dropped.
- Encoding: FREEZE is kept as a legal state encoding for future multi-cycle freezes. It is currently unreachable; decoding it returns to RUN.

## Timing
- Stall path: stallreq_i to stall_o, 0 cycles (combinational).
- Exception at edge n: stall_o all ones during cycle n.
- flush_o is high from cycle n+1 through n+FLUSH_CYCLES. New_pc_o is stable over the same window.
- First new exception accepted in cycle n+FLUSH_CYCLES+1.
- Back-to-back requests: exc_req_i high in the last FLUSH cycle is ignored. The requesting stage must hold it into RUN.

## Configuration
- Macro PIPE_CTRL_STALL_CNT_EN.
- Defined:
  - stall_cnt_o is present.
  - It is a 32-bit counter incremented on every RUN cycle with stall_o≠0.
  - It saturates at 32'hFFFF_FFFF and clears only on rst.
  - FREEZE/exception cycles are not counted.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared defines header: EXC_ERET (5'h1F), the state encodings (RUN=2'd0, FREEZE=2'd1, FLUSH=2'd2), and the default EXC_BASE.
- Sub-module stall_mask_gen: combinational, parametrised by STAGES. It maps stallreq_i to a thermometer mask via a highest-set-bit priority scan.
- The FSM, counters and registers live in pipe_ctrl.

## Test plan
- Reset, with STAGES=6: assert rst with random inputs → stall_o=6'b000000, flush_o=0, new_pc_o=0, stall_cnt_o=0.
- Stall priority:
  - stallreq_i=6'b000100 → stall_o=6'b000111 in the same cycle.
  - stallreq_i=6'b001100 → stall_o=6'b001111.
  - stallreq_i=6'b000000 → stall_o=6'b000000.
- Exception: exc_req_i=1, exc_code_i=5'h08, stallreq_i=6'b001000 at cycle n.
  - Cycle n: stall_o=6'b111111.
  - Cycle n+1: flush_o=1, new_pc_o=32'h20.
  - Cycle n+2: flush_o=0, and stall_o follows stallreq_i.
- ERET with FLUSH_CYCLES=3: exc_code_i=5'h1F, epc_i=32'h1000_0040.
  - flush_o is high for cycles n+1..n+3 with new_pc_o=32'h1000_0040.
  - A second exc_req_i at n+2 is ignored.
- Reset mid-flush: assert rst at cycle n+1 of a flush → flush_o=0 and stall_o=0 immediately, FSM in RUN after release.
- Counter, macro defined: 10 stalled RUN cycles plus 1 exception cycle → stall_cnt_o=10. Preload near the maximum → the counter holds at 32'hFFFF_FFFF.
